keypad_row_scanner: RTL and testbench
=====================================

// Module: keypad_row_scanner
// PURPOSE
//   Drives the 4x4 keypad rows (one-hot, active-low) and reads the column lines
//   after the 2-flop column synchronizer (sync_col, active-low). Debounces press
//   and release, then reports one 4-bit key code per physical press.
//   Sits between the synchronizer and the display/key-history logic.
// PARAMETERS
//   SCAN_DIV         4     clk cycles each row is driven while scanning; must be >= 3
//   DEBOUNCE_CYCLES  20000 consecutive stable cycles required to accept a press or release
// PORTS
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-low reset
//   sync_col   in   4  synchronized column inputs, bit i low = column i pulled low
//   row        out  4  row drive, one-hot active-low, bit r low = row r driven
//   key_code   out  4  {row_idx[1:0], col_idx[1:0]} of last accepted key
//   key_valid  out  1  one-cycle pulse when a new key is accepted
//   key_held   out  1  high while the accepted key is pressed or release-debouncing
// BEHAVIOUR
// - All state updates on posedge clk. reset==0 at an edge forces: state=SCAN,
//   row=4'b1110, row_idx=0, dwell and debounce counters=0, key_code=0, key_valid=0,
//   key_held=0. Reset mid-press discards the press; no key_valid follows.
// - Column sample is valid only on the last dwell cycle of a row
//   (dwell==SCAN_DIV-1), covering the 2-cycle synchronizer latency.
// - Single-press pattern: sync_col has exactly one 0 bit (1110/1101/1011/0111).
//   All other non-1111 patterns (two or more columns low) are ignored as no press.
// - SCAN: dwell counts 0..SCAN_DIV-1. On the sample cycle, a single-press pattern
//   -> DEBOUNCE, latch pattern, keep row. Otherwise row_idx increments mod 4
//   (3 -> 0), row rotates left (1110 -> 1101 -> 1011 -> 0111 -> 1110), dwell=0.
// - DEBOUNCE: row held. Each cycle sync_col==latched -> counter++; mismatch ->
//   SCAN on the same row, dwell=0, counter=0. When counter reaches
//   DEBOUNCE_CYCLES-1 on a matching cycle -> PRESSED.
// - PRESSED: on entry cycle key_valid=1 (exactly one cycle), key_code={row_idx,
//   col_idx} registered the same cycle, key_held=1. Stay while sync_col!=1111.
//   On sync_col==1111 -> RELEASE, counter=0. Other keys pressed meanwhile are ignored.
// - RELEASE: row held, key_held=1. sync_col==1111 -> counter++; any column low ->
//   PRESSED without a new key_valid, counter=0. When counter reaches
//   DEBOUNCE_CYCLES-1 -> SCAN, key_held=0, row advances to the next row, dwell=0.
// - key_code holds its value until the next key_valid; it is not cleared on release.
// - Counter widths are $clog2(param)+1 bits; no counter wraps.
// - Latency: press visible on sync_col at sample cycle S -> key_valid at
//   S+DEBOUNCE_CYCLES+1 if the pattern stays stable.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CYCLES=8, 10 ns clk)
//   1 Hold reset=0 for 3 edges, release, sync_col=1111 for 32 cycles -> row cycles
//     1110,1101,1011,0111,1110 every 4 clks; key_valid never 1; key_code=0.
//   2 Drive sync_col=1011 only while row==1101, held 20 cycles -> one key_valid pulse,
//     key_code=4'b0110, key_held=1; row stays 1101 for the whole press.
//   3 Bounce: on row 0, col 0 low for 5 cycles then 1111 for 1 cycle, repeat 3 times ->
//     no key_valid, scanning resumes on row 1110 after each bounce.
//   4 Release with 3-cycle glitch back to pressed mid-RELEASE -> no second key_valid;
//     key_held drops 8+ cycles after final stable 1111; row advances one step.
//   5 Two columns low (sync_col=1010) on row 2 for 20 cycles -> no key_valid, row keeps
//     rotating.
//   6 Assert reset=0 during PRESSED (key 4'b1111 held) -> next edge row=1110,
//     key_held=0, key_code=0, no key_valid after reset deasserts while held key stays.

Source files
------------

// File: rtl/keypad_row_scanner.sv
// rtl/keypad_row_scanner.sv - 4x4 keypad row scanner with press/release debounce
//
// Purpose: drives one keypad row at a time (active-low), samples the
// synchronized column lines at the end of each row dwell, debounces a
// single-key press and its release, and reports one key code per press.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-low reset
//   sync_col   in   4  synchronized columns, bit i low = column i pulled low
//   row        out  4  row drive, one-hot active-low
//   key_code   out  4  {row_idx, col_idx} of the last accepted key
//   key_valid  out  1  one-cycle pulse when a new key is accepted
//   key_held   out  1  high while the accepted key is pressed or release-debouncing

module keypad_row_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sync_col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t        state_q;
    logic [3:0]    row_q;
    logic [1:0]    row_idx_q;
    logic [DW-1:0] dwell_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    latched_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;

    // Decode of the current column sample: only exactly one low column is a
    // press; any multi-column pattern is treated as no press.
    logic       col_single;
    logic [1:0] col_idx;

    always_comb begin
        col_single = 1'b0;
        col_idx    = 2'd0;
        case (sync_col)
            4'b1110: begin col_single = 1'b1; col_idx = 2'd0; end
            4'b1101: begin col_single = 1'b1; col_idx = 2'd1; end
            4'b1011: begin col_single = 1'b1; col_idx = 2'd2; end
            4'b0111: begin col_single = 1'b1; col_idx = 2'd3; end
            default: begin col_single = 1'b0; col_idx = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_SCAN;
            row_q       <= 4'b1110;
            row_idx_q   <= 2'd0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            latched_q   <= 4'b1111;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                S_SCAN: begin
                    // Columns are only trusted on the last dwell cycle, after
                    // the synchronizer has caught up with the new row.
                    if (dwell_q == DWELL_LAST) begin
                        if (col_single) begin
                            state_q   <= S_DEBOUNCE;
                            latched_q <= sync_col;
                            cnt_q     <= '0;
                        end else begin
                            row_idx_q <= row_idx_q + 2'd1;
                            row_q     <= {row_q[2:0], row_q[3]};
                            dwell_q   <= '0;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end

                S_DEBOUNCE: begin
                    if (sync_col != latched_q) begin
                        // Bounce: resume scanning on the same row.
                        state_q <= S_SCAN;
                        dwell_q <= '0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= S_PRESSED;
                        key_valid_q <= 1'b1;
                        key_code_q  <= {row_idx_q, col_idx};
                        key_held_q  <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_PRESSED: begin
                    if (sync_col == 4'b1111) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                    end
                end

                S_RELEASE: begin
                    if (sync_col != 4'b1111) begin
                        // Release glitch: back to held, no new key reported.
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= S_SCAN;
                        key_held_q <= 1'b0;
                        row_idx_q  <= row_idx_q + 2'd1;
                        row_q      <= {row_q[2:0], row_q[3]};
                        dwell_q    <= '0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_SCAN;
                    dwell_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_row_scanner.sv
// tb/tb_keypad_row_scanner.sv - self-checking bench for keypad_row_scanner

module tb_keypad_row_scanner;

    localparam int SD  = 4;
    localparam int DEB = 8;

    localparam int P_SCAN = 0;
    localparam int P_DEB  = 1;
    localparam int P_PRS  = 2;
    localparam int P_REL  = 3;

    logic       clk;
    logic       reset;
    logic [3:0] sync_col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_row_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sync_col  (sync_col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    // Reference model: phase, active row number, dwell position and length of
    // the current stable run of column samples.
    int         m_phase;
    int         m_row;
    int         m_dwell;
    int         m_run;
    logic [3:0] m_pat;
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_held;

    function automatic int one_low(input logic [3:0] c);
        int z;
        int idx;
        z = 0;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (!c[i]) begin
                z++;
                idx = i;
            end
        end
        return (z == 1) ? idx : -1;
    endfunction

    function automatic logic [3:0] row_drive(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return 4'hF ^ (one << r);
    endfunction

    task model_step(input logic r, input logic [3:0] c);
        m_valid = 1'b0;
        if (!r) begin
            m_phase = P_SCAN; m_row = 0; m_dwell = 0; m_run = 0;
            m_code = 4'd0; m_held = 1'b0; m_pat = 4'hF;
        end else begin
            case (m_phase)
                P_SCAN: begin
                    if (m_dwell == SD - 1) begin
                        if (one_low(c) >= 0) begin
                            m_phase = P_DEB; m_pat = c; m_run = 0;
                        end else begin
                            m_row = (m_row + 1) % 4; m_dwell = 0;
                        end
                    end else begin
                        m_dwell++;
                    end
                end
                P_DEB: begin
                    if (c != m_pat) begin
                        m_phase = P_SCAN; m_dwell = 0;
                    end else begin
                        m_run++;
                        if (m_run == DEB) begin
                            m_phase = P_PRS; m_valid = 1'b1; m_held = 1'b1;
                            m_code = 4'(m_row * 4 + one_low(m_pat));
                        end
                    end
                end
                P_PRS: begin
                    if (c == 4'hF) begin
                        m_phase = P_REL; m_run = 0;
                    end
                end
                default: begin
                    if (c != 4'hF) begin
                        m_phase = P_PRS;
                    end else begin
                        m_run++;
                        if (m_run == DEB) begin
                            m_phase = P_SCAN; m_held = 1'b0;
                            m_row = (m_row + 1) % 4; m_dwell = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample after the edge.
    task tick(input logic r, input logic [3:0] c);
        reset = r;
        sync_col = c;
        model_step(r, c);
        @(posedge clk);
        #1;
        if (key_valid === 1'b1) vcount++;
        chk("model", {row, key_valid, key_held, key_code},
            {row_drive(m_row), m_valid, m_held, m_code});
    endtask

    task wait_row(input logic [3:0] target, input int budget);
        int n;
        n = 0;
        while (row !== target && n < budget) begin
            tick(1'b1, 4'hF);
            n++;
        end
        chk("wait_row", {28'd0, row}, {28'd0, target});
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] col;
        logic [3:0] exp_row;
        logic       exp_valid;
        logic       exp_held;
        logic [3:0] exp_code;
    } vec_t;

    vec_t tbl[35];

    initial begin
        int v0;
        int n;
        int changes;
        logic stuck_ok;
        logic [3:0] prev_row;
        logic [3:0] one;

        one = 4'b0001;
        for (int i = 0; i < 35; i++) begin
            tbl[i].rst       = (i < 3) ? 1'b0 : 1'b1;
            tbl[i].col       = 4'hF;
            tbl[i].exp_valid = 1'b0;
            tbl[i].exp_held  = 1'b0;
            tbl[i].exp_code  = 4'd0;
            if (i < 3) tbl[i].exp_row = 4'b1110;
            else       tbl[i].exp_row = 4'hF ^ (one << (((i - 2) / 4) % 4));
        end

        reset = 1'b0;
        sync_col = 4'hF;

        // Reset then idle scanning.
        for (int i = 0; i < 35; i++) begin
            tick(tbl[i].rst, tbl[i].col);
            chk("vec", {row, key_valid, key_held, key_code},
                {tbl[i].exp_row, tbl[i].exp_valid, tbl[i].exp_held, tbl[i].exp_code});
        end
        chk("idle_no_valid", vcount, 0);

        // Press column 2 on row 1.
        wait_row(4'b1101, 40);
        v0 = vcount;
        stuck_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, (row == 4'b1101) ? 4'b1011 : 4'hF);
            if (row !== 4'b1101) stuck_ok = 1'b0;
        end
        chk("press_one_valid", vcount - v0, 1);
        chk("press_code", key_code, 4'b0110);
        chk("press_held", key_held, 1'b1);
        chk("press_row_stays", stuck_ok, 1'b1);
        for (int i = 0; i < 12; i++) tick(1'b1, 4'hF);
        chk("release_held", key_held, 1'b0);
        chk("release_row_adv", row, 4'b1011);
        chk("release_code_kept", key_code, 4'b0110);

        // Bounce on row 0.
        wait_row(4'b1110, 40);
        v0 = vcount;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 5; i++) tick(1'b1, 4'b1110);
            tick(1'b1, 4'hF);
            chk("bounce_row", row, 4'b1110);
        end
        chk("bounce_no_valid", vcount - v0, 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'hF);
        chk("bounce_resume", row, 4'b1101);

        // Release glitch.
        wait_row(4'b1110, 40);
        v0 = vcount;
        for (int i = 0; i < 14; i++) tick(1'b1, (row == 4'b1110) ? 4'b1101 : 4'hF);
        chk("glitch_press", vcount - v0, 1);
        chk("glitch_code", key_code, 4'b0001);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'hF);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'b1101);
        chk("glitch_held_mid", key_held, 1'b1);
        n = 0;
        while (key_held === 1'b1 && n < 30) begin
            tick(1'b1, 4'hF);
            n++;
        end
        chk("glitch_drop_cycles", n, DEB + 1);
        chk("glitch_no_second", vcount - v0, 1);
        chk("glitch_row_adv", row, 4'b1101);

        // Two columns low on row 2.
        wait_row(4'b1011, 40);
        v0 = vcount;
        changes = 0;
        prev_row = row;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 4'b1010);
            if (row !== prev_row) changes++;
            prev_row = row;
        end
        chk("multi_no_valid", vcount - v0, 0);
        chk("multi_rotations", changes, 5);

        // Reset during a held key.
        wait_row(4'b0111, 40);
        v0 = vcount;
        for (int i = 0; i < 14; i++) tick(1'b1, (row == 4'b0111) ? 4'b0111 : 4'hF);
        chk("rst_press", vcount - v0, 1);
        chk("rst_press_code", key_code, 4'b1111);
        tick(1'b0, 4'b0111);
        chk("rst_state", {row, key_valid, key_held, key_code}, {4'b1110, 1'b0, 1'b0, 4'd0});
        v0 = vcount;
        for (int i = 0; i < 12; i++) tick(1'b1, (row == 4'b0111) ? 4'b0111 : 4'hF);
        chk("rst_no_valid", vcount - v0, 0);

        // Randomized segments against the model.
        for (int s = 0; s < 150; s++) begin
            int kind;
            int len;
            logic [3:0] c;
            kind = $urandom_range(0, 19);
            len  = $urandom_range(1, 25);
            if (kind < 8)       c = 4'hF;
            else if (kind < 15) c = row_drive($urandom_range(0, 3));
            else if (kind < 19) c = 4'($urandom_range(0, 15));
            else                c = 4'hF;
            if (kind == 19) begin
                for (int i = 0; i < $urandom_range(1, 2); i++) tick(1'b0, 4'($urandom_range(0, 15)));
            end else begin
                for (int i = 0; i < len; i++) tick(1'b1, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
